// File: rtl/data_read_pkg.sv
// Shared types and width helpers for the multi-channel ping-pong capture buffer.
package data_read_pkg;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_DEPTH    = 8192;
    localparam int DEF_RD_WIDTH = 32;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_READY,
        BANK_READING
    } bank_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_FILL,
        WR_WAIT
    } wr_state_t;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    localparam int DEF_CH_W   = clog2_min1(DEF_NUM_CH);
    localparam int DEF_WORD_W = clog2_min1(DEF_DEPTH / DEF_RD_WIDTH);
    localparam int DEF_CNT_W  = clog2_min1(DEF_DEPTH);

endpackage

// File: rtl/data_read_bank_ram.sv
// Two-bank sample store: one RAM lane per channel so a completed word of every
// channel is written in the same cycle; registered read selects bank/channel/word.
module data_read_bank_ram
    import data_read_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WORDS  = DEF_DEPTH / DEF_RD_WIDTH,
    parameter int WIDTH  = DEF_RD_WIDTH,
    parameter int WORD_W = clog2_min1(WORDS),
    parameter int CH_W   = clog2_min1(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic                           wr_bank,
    input  logic [WORD_W-1:0]              wr_word,
    input  logic [NUM_CH-1:0][WIDTH-1:0]   wr_data,
    input  logic                           rd_en,
    input  logic                           rd_bank,
    input  logic [CH_W-1:0]                rd_ch,
    input  logic [WORD_W-1:0]              rd_word,
    output logic [WIDTH-1:0]               rd_data
);

    logic [NUM_CH-1:0][WIDTH-1:0] lane_word;
    logic [CH_W-1:0]              rd_ch_q;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            logic [WIDTH-1:0] mem [2*WORDS];
            logic [WIDTH-1:0] word_q;

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[{wr_bank, wr_word}] <= wr_data[gi];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= '0;
                end else if (rd_en) begin
                    word_q <= mem[{rd_bank, rd_word}];
                end
            end

            assign lane_word[gi] = word_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ch_q <= '0;
        end else if (rd_en) begin
            rd_ch_q <= rd_ch;
        end
    end

    assign rd_data = lane_word[rd_ch_q];

endmodule

// File: rtl/data_read_pingpong_buffer.sv
// Captures one bit per channel per beat into per-channel words, alternating
// between two banks so the bus side reads a finished bank while the next fills.
module data_read_pingpong_buffer
    import data_read_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RD_WIDTH = DEF_RD_WIDTH,
    localparam int CH_W    = clog2_min1(NUM_CH),
    localparam int WORD_W  = clog2_min1(DEPTH / RD_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 wr_valid,
    input  logic [NUM_CH-1:0]    wr_data,
    input  logic                 rd_en,
    input  logic [WORD_W-1:0]    rd_addr,
    input  logic [CH_W-1:0]      rd_ch_sel,
    output logic [RD_WIDTH-1:0]  rd_data,
    output logic                 rd_valid,
    input  logic                 rd_release,
    output logic                 bank_ready,
    output logic                 rd_bank,
    output logic                 wr_busy,
    output logic                 overflow,
    input  logic                 overflow_clr
);

    localparam int CNT_W   = clog2_min1(DEPTH);
    localparam int RDW_LOG = $clog2(RD_WIDTH);

    wr_state_t                       wr_state_q, wr_state_d;
    logic                            wr_bank_q, wr_bank_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [NUM_CH-1:0][RD_WIDTH-1:0] asm_q, asm_d, shift_word;
    bank_state_t                     bank_st_q [2];
    bank_state_t                     bank_st_d [2];
    logic                            rd_bank_q, rd_bank_d;
    logic                            bank_ready_q, bank_ready_d;
    logic                            overflow_q, overflow_d;
    logic                            rd_valid_q, rd_valid_d;
    logic                            wr_busy_q, wr_busy_d;

    logic                            release_eff;
    logic [1:0]                      free_eff;
    logic                            rd_other, wr_other;
    logic                            word_done, bank_done;
    logic                            ram_wr_en, ram_rd_en;
    logic                            drop;
    logic [WORD_W-1:0]               wr_word;

    // Oldest sample ends at bit 0 after RD_WIDTH shifts in from the top.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_shift
            assign shift_word[gi] = {wr_data[gi], asm_q[gi][RD_WIDTH-1:1]};
        end
    endgenerate

    assign rd_other    = ~rd_bank_q;
    assign wr_other    = ~wr_bank_q;
    assign release_eff = rd_release && bank_ready_q;
    assign word_done   = (count_q[RDW_LOG-1:0] == {RDW_LOG{1'b1}});
    assign bank_done   = (count_q == CNT_W'(DEPTH - 1));
    assign wr_word     = WORD_W'(count_q >> RDW_LOG);
    assign ram_rd_en   = rd_en && bank_ready_q;

    // A bank released this cycle counts as free so the writer never loses a beat.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            free_eff[b] = (bank_st_q[b] == BANK_FREE) ||
                          (release_eff && (rd_bank_q == 1'(b)));
        end
    end

    always_comb begin
        wr_state_d   = wr_state_q;
        wr_bank_d    = wr_bank_q;
        count_d      = count_q;
        asm_d        = asm_q;
        bank_st_d    = bank_st_q;
        rd_bank_d    = rd_bank_q;
        bank_ready_d = bank_ready_q;
        overflow_d   = overflow_q;
        ram_wr_en    = 1'b0;
        drop         = 1'b0;

        if (release_eff) begin
            bank_st_d[rd_bank_q] = BANK_FREE;
            if (bank_st_q[rd_other] == BANK_READY) begin
                bank_st_d[rd_other] = BANK_READING;
                rd_bank_d           = rd_other;
            end else begin
                bank_ready_d = 1'b0;
            end
        end else if (!bank_ready_q) begin
            if (bank_st_q[rd_other] == BANK_READY) begin
                bank_st_d[rd_other] = BANK_READING;
                rd_bank_d           = rd_other;
                bank_ready_d        = 1'b1;
            end else if (bank_st_q[rd_bank_q] == BANK_READY) begin
                bank_st_d[rd_bank_q] = BANK_READING;
                bank_ready_d         = 1'b1;
            end
        end

        case (wr_state_q)
            WR_IDLE: begin
                if (enable) begin
                    if (free_eff[wr_bank_q]) begin
                        wr_state_d           = WR_FILL;
                        count_d              = '0;
                        bank_st_d[wr_bank_q] = BANK_FILLING;
                    end else if (free_eff[wr_other]) begin
                        wr_state_d          = WR_FILL;
                        wr_bank_d           = wr_other;
                        count_d             = '0;
                        bank_st_d[wr_other] = BANK_FILLING;
                    end
                end
            end
            WR_FILL: begin
                if (!enable) begin
                    wr_state_d           = WR_IDLE;
                    count_d              = '0;
                    bank_st_d[wr_bank_q] = BANK_FREE;
                end else if (wr_valid) begin
                    asm_d     = shift_word;
                    ram_wr_en = word_done;
                    if (bank_done) begin
                        count_d              = '0;
                        bank_st_d[wr_bank_q] = BANK_READY;
                        wr_bank_d            = wr_other;
                        if (free_eff[wr_other]) begin
                            bank_st_d[wr_other] = BANK_FILLING;
                        end else begin
                            wr_state_d = WR_WAIT;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            WR_WAIT: begin
                if (!enable) begin
                    wr_state_d = WR_IDLE;
                    count_d    = '0;
                end else begin
                    drop = wr_valid;
                    if (free_eff[wr_bank_q]) begin
                        wr_state_d           = WR_FILL;
                        count_d              = '0;
                        bank_st_d[wr_bank_q] = BANK_FILLING;
                    end
                end
            end
            default: begin
                wr_state_d = WR_IDLE;
            end
        endcase

        if (overflow_clr) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    assign rd_valid_d = ram_rd_en;
    assign wr_busy_d  = (wr_state_d == WR_FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q   <= WR_IDLE;
            wr_bank_q    <= 1'b0;
            count_q      <= '0;
            asm_q        <= '0;
            bank_st_q    <= '{BANK_FREE, BANK_FREE};
            rd_bank_q    <= 1'b0;
            bank_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            wr_busy_q    <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_bank_q    <= wr_bank_d;
            count_q      <= count_d;
            asm_q        <= asm_d;
            bank_st_q    <= bank_st_d;
            rd_bank_q    <= rd_bank_d;
            bank_ready_q <= bank_ready_d;
            overflow_q   <= overflow_d;
            rd_valid_q   <= rd_valid_d;
            wr_busy_q    <= wr_busy_d;
        end
    end

    data_read_bank_ram #(
        .NUM_CH (NUM_CH),
        .WORDS  (DEPTH / RD_WIDTH),
        .WIDTH  (RD_WIDTH),
        .WORD_W (WORD_W),
        .CH_W   (CH_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_wr_en),
        .wr_bank (wr_bank_q),
        .wr_word (wr_word),
        .wr_data (shift_word),
        .rd_en   (ram_rd_en),
        .rd_bank (rd_bank_q),
        .rd_ch   (rd_ch_sel),
        .rd_word (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_valid   = rd_valid_q;
    assign bank_ready = bank_ready_q;
    assign rd_bank    = rd_bank_q;
    assign wr_busy    = wr_busy_q;
    assign overflow   = overflow_q;

endmodule
